// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage core. Owns the program counter,
//   drives the word address into a combinational instruction memory and
//   captures the returned instruction into the IF/ID pipeline register.
//   Honours stall/flush from the hazard unit and redirects from EX, and stops
//   fetching after an EBREAK until a redirect arrives.
//
// Ports
//   clk                core clock, rising edge
//   reset              asynchronous, active-low reset
//   stall              hold PC and IF/ID contents
//   flush              replace IF/ID contents with a bubble
//   redirect_valid     load a new PC (taken branch/jump)
//   redirect_pc        redirect target, byte address
//   imem_addr          word address to instruction memory
//   imem_instruction   instruction returned combinationally for imem_addr
//   if_id_pc           PC of the captured instruction
//   if_id_pc_plus4     if_id_pc + 4 (wrapping)
//   if_id_instruction  captured instruction
//   if_id_valid        IF/ID holds a real instruction
//   halted             fetch is parked after an EBREAK
//   misaligned_fault   sticky: a redirect target had nonzero bits [1:0]
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              XLEN               = 32,
  parameter int              WORD_ADDRESS       = 10,
  parameter logic [XLEN-1:0] RESET_PC           = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTRUCTION    = 32'h0000_0013,
  parameter logic [XLEN-1:0] EBREAK_INSTRUCTION = 32'h0010_0073
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [WORD_ADDRESS-1:0] imem_addr,
  input  logic [XLEN-1:0]         imem_instruction,
  output logic [XLEN-1:0]         if_id_pc,
  output logic [XLEN-1:0]         if_id_pc_plus4,
  output logic [XLEN-1:0]         if_id_instruction,
  output logic                    if_id_valid,
  output logic                    halted,
  output logic                    misaligned_fault
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next, pc_plus4;
  logic [XLEN-1:0] if_id_pc_next, if_id_pc_plus4_next, if_id_instruction_next;
  logic            if_id_valid_next, misaligned_fault_next;

  assign imem_addr = pc[WORD_ADDRESS+1:2];
  assign pc_plus4  = pc + PC_STEP;
  assign halted    = (state == HALT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if chain can leave one unassigned and infer a latch.
  always_comb begin
    state_next             = state;
    pc_next                = pc;
    if_id_pc_next          = if_id_pc;
    if_id_pc_plus4_next    = if_id_pc_plus4;
    if_id_instruction_next = if_id_instruction;
    if_id_valid_next       = if_id_valid;
    misaligned_fault_next  = misaligned_fault;

    if (state == BOOT) begin
      // First cycle after reset: memory output is not trusted yet, so insert
      // a bubble regardless of stall and start fetching next edge.
      if_id_instruction_next = NOP_INSTRUCTION;
      if_id_valid_next       = 1'b0;
      state_next             = RUN;
    end else if (redirect_valid) begin
      pc_next                = {redirect_pc[XLEN-1:2], 2'b00};
      if_id_instruction_next = NOP_INSTRUCTION;
      if_id_valid_next       = 1'b0;
      state_next             = RUN;
      if (redirect_pc[1:0] != 2'b00) misaligned_fault_next = 1'b1;
    end else if (flush) begin
      if_id_instruction_next = NOP_INSTRUCTION;
      if_id_valid_next       = 1'b0;
      // A flushed fetch slot still consumes its PC unless stalled; in HALT
      // the PC stays frozen.
      if (!stall && state == RUN) pc_next = pc_plus4;
    end else if (stall) begin
      // Hold everything.
    end else if (state == HALT) begin
      if_id_instruction_next = NOP_INSTRUCTION;
      if_id_valid_next       = 1'b0;
    end else begin
      if_id_pc_next          = pc;
      if_id_pc_plus4_next    = pc_plus4;
      if_id_instruction_next = imem_instruction;
      if_id_valid_next       = 1'b1;
      pc_next                = pc_plus4;
      // The EBREAK itself flows down the pipe; only later fetches stop.
      if (imem_instruction == EBREAK_INSTRUCTION) state_next = HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= BOOT;
      pc                <= RESET_PC;
      if_id_pc          <= '0;
      if_id_pc_plus4    <= '0;
      if_id_instruction <= NOP_INSTRUCTION;
      if_id_valid       <= 1'b0;
      misaligned_fault  <= 1'b0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      if_id_pc          <= if_id_pc_next;
      if_id_pc_plus4    <= if_id_pc_plus4_next;
      if_id_instruction <= if_id_instruction_next;
      if_id_valid       <= if_id_valid_next;
      misaligned_fault  <= misaligned_fault_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The driver applies one set of inputs per
//   cycle on the falling edge, advances a behavioural model of the fetch rules
//   and pushes the expected post-edge outputs; the monitor pops one entry
//   after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [9:0]  imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instruction;
  logic        if_id_valid, halted, misaligned_fault;

  logic [31:0] mem [1024];
  assign imem_instruction = mem[imem_addr];

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .halted           (halted),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic [31:0] instr;
    logic        valid;
    logic        halt;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  // Behavioural model: architectural fetch state.
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr;
  bit          m_boot, m_halt, m_valid, m_fault;

  task automatic model_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = NOP;
    m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  // Apply inputs for the coming rising edge, predict its outcome, then wait
  // for the next falling edge. Must be entered on a falling edge.
  task automatic step(input bit s, input bit f, input bit rv, input logic [31:0] rpc);
    exp_t e;
    logic [31:0] word;
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    if (m_boot) begin
      bubble();
      m_boot = 1'b0;
    end else if (rv) begin
      m_pc = rpc - (rpc % 4);
      bubble();
      m_halt = 1'b0;
      if (rpc % 4 != 0) m_fault = 1'b1;
    end else if (f) begin
      bubble();
      if (!s && !m_halt) m_pc = m_pc + 4;
    end else if (s) begin
      // nothing moves
    end else if (m_halt) begin
      bubble();
    end else begin
      word    = mem[(m_pc / 4) % 1024];
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 4;
      m_instr = word;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      if (word == EBREAK) m_halt = 1'b1;
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.ifpc4 = m_ifpc4; e.instr = m_instr;
    e.valid = m_valid; e.halt = m_halt; e.fault = m_fault;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".imem_addr"}, {22'h0, imem_addr}, 32'h0);
    check({tag, ".if_id_pc"}, if_id_pc, 32'h0);
    check({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, 32'h0);
    check({tag, ".if_id_instruction"}, if_id_instruction, NOP);
    check({tag, ".if_id_valid"}, {31'h0, if_id_valid}, 32'h0);
    check({tag, ".halted"}, {31'h0, halted}, 32'h0);
    check({tag, ".misaligned_fault"}, {31'h0, misaligned_fault}, 32'h0);
  endtask

  // Leaves reset released on a falling edge; the next step() is edge 1 (BOOT).
  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
  endtask

  // Monitor: one scoreboard entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("imem_addr", {22'h0, imem_addr}, {22'h0, e.pc[11:2]});
        check("if_id_pc", if_id_pc, e.ifpc);
        check("if_id_pc_plus4", if_id_pc_plus4, e.ifpc4);
        check("if_id_instruction", if_id_instruction, e.instr);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
        check("halted", {31'h0, halted}, {31'h0, e.halt});
        check("misaligned_fault", {31'h0, misaligned_fault}, {31'h0, e.fault});
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    int r;

    // Directed program: two real instructions, then NOPs.
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;

    do_reset();
    run(5);                                  // BOOT, then pc 0,4,8,C -> pc=0x10
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0); // stall at pc=0x10
    run(1);                                  // captures pc=0x10
    step(1'b1, 1'b1, 1'b1, 32'h40);          // redirect beats flush and stall
    run(1);                                  // captures pc=0x40
    step(1'b0, 1'b1, 1'b0, 32'h0);           // flush without stall
    step(1'b1, 1'b1, 1'b0, 32'h0);           // flush with stall
    step(1'b0, 1'b0, 1'b1, 32'h42);          // misaligned redirect
    run(10);                                 // fault stays sticky

    // EBREAK at word 3: halt with pc frozen at 0x10, then resume.
    mem[3] = EBREAK;
    step(1'b0, 1'b0, 1'b1, 32'h0);
    run(4);
    run(3);                                  // bubbles while halted
    step(1'b1, 1'b0, 1'b0, 32'h0);           // stall in HALT
    step(1'b0, 1'b1, 1'b0, 32'h0);           // flush in HALT keeps pc frozen
    step(1'b0, 1'b0, 1'b1, 32'h0);           // redirect releases HALT
    run(2);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(2);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_values("async_reset");
    sb.delete();

    // Randomized traffic over a random program with sprinkled EBREAKs.
    for (int i = 0; i < 1024; i++) begin
      r = $urandom_range(0, 15);
      mem[i] = (r == 0) ? EBREAK : $urandom;
    end
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      rpc = $urandom;
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, r < 8, rpc);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage core. Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from the hazard unit and EX stage.
- Stops fetching on EBREAK until a redirect arrives.

Parameters:
- XLEN, 32, datapath and PC width
- WORD_ADDRESS, 10, instruction-memory word-address width
- RESET_PC, 32'h00000000, byte address of first fetch
- NOP_INSTRUCTION, 32'h00000013, bubble encoding (addi x0,x0,0)
- EBREAK_INSTRUCTION, 32'h00100073, halt-trigger encoding

Ports:
- clk  in  1  core clock, rising-edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace IF/ID contents with a bubble
- redirect_valid  in  1  load new PC (taken branch/jump)
- redirect_pc  in  XLEN  redirect target, byte address
- imem_addr  out  WORD_ADDRESS  word address to instruction memory
- imem_instruction  in  XLEN  instruction returned combinationally for imem_addr
- if_id_pc  out  XLEN  PC of the captured instruction
- if_id_pc_plus4  out  XLEN  if_id_pc + 4, mod 2^XLEN
- if_id_instruction  out  XLEN  captured instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  FSM in HALT
- misaligned_fault  out  1  sticky: redirect target had nonzero bits [1:0]

Behaviour:
- imem_addr = pc[WORD_ADDRESS+1:2], combinational from the PC register. Out-of-range addresses are the memory's concern; the memory returns NOP.
- Reset (reset==0, async) values:
  - pc=RESET_PC, state=BOOT
  - if_id_pc=0, if_id_pc_plus4=0
  - if_id_instruction=NOP_INSTRUCTION, if_id_valid=0
  - halted=0, misaligned_fault=0
- FSM states BOOT, RUN, HALT. All updates occur on the rising clk edge.
- BOOT: lasts one cycle after reset release.
  - pc held; IF/ID loads a bubble; next state RUN.
  - stall is ignored in BOOT.
- Per-edge priority in RUN/HALT: redirect_valid > flush > stall > normal.
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - IF/ID <= bubble (valid=0, instruction=NOP, pc fields unchanged).
  - state <= RUN, which also exits HALT.
  - If redirect_pc[1:0]!=0, set misaligned_fault; it stays 1 until reset.
  - stall is ignored when redirect_valid is asserted.
- Flush without redirect:
  - IF/ID <= bubble.
  - pc advances by 4 if stall=0; pc is held if stall=1.
- Stall without redirect/flush: pc and all IF/ID outputs hold their values.
- Normal RUN:
  - if_id_pc<=pc; if_id_pc_plus4<=pc+4; if_id_instruction<=imem_instruction; if_id_valid<=1.
  - pc<=pc+4, wrapping mod 2^XLEN.
- HALT entry: on a normal RUN capture where imem_instruction==EBREAK_INSTRUCTION.
  - The EBREAK is captured normally (valid=1) and pc<=pc+4.
  - state<=HALT.
- HALT:
  - pc frozen.
  - IF/ID loads a bubble each non-stalled edge; stall holds IF/ID.
  - halted=1.
  - Only a redirect or reset leaves HALT.
- Pipeline latency: an instruction at PC p appears on IF/ID one edge after pc==p with no stall.
- The first valid IF/ID (RESET_PC) appears on the 2nd rising edge after reset deassertion.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
- Reset release, imem returns 0x00500093 at word 0 and 0x00A00113 at word 1 -> edge1 bubble (BOOT); edge2 IF/ID={pc=0, pc+4=4, 0x00500093, valid=1}; edge3 pc=0x8, IF/ID pc=0x4.
- Stall high 3 cycles at pc=0x10 -> pc stays 0x10 and IF/ID stays unchanged; after release, next edge captures pc=0x10.
- redirect_valid=1, redirect_pc=0x40, together with stall=1 and flush=1 -> next edge pc=0x40, if_id_valid=0; following edge captures pc=0x40.
- redirect_pc=0x42 -> pc=0x40 and misaligned_fault=1, still 1 after 10 further cycles; cleared only by reset.
- EBREAK at word 3 -> IF/ID captures 0x00100073 valid=1; pc=0x10 frozen; halted=1; subsequent IF/ID are bubbles. Redirect to 0x0 -> halted=0 and fetch resumes.
- pc=0xFFFFFFFC (XLEN=32) normal fetch -> if_id_pc_plus4=0x00000000 and pc wraps to 0; assert reset mid-cycle -> outputs return to reset values before the next edge.
